apu_pulse_channel: RTL

Square-wave audio voice that decodes CPU writes from the shared 8-bit memory bus and produces a 4-bit sample stream. It sits directly upstream of the audio output module, which consumes `sample`. The channel includes a duty sequencer, an 11-bit period timer, a length counter and a volume envelope. Behaviour follows the NES pulse channel, scaled to this design's clock.

---
 rtl/apu_pkg.sv | 28 ++
 rtl/apu_envelope.sv | 47 ++++
 rtl/apu_pulse_channel.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/apu_pkg.sv
// Shared constants for the pulse channel: register offsets, duty patterns and length table.
package apu_pkg;

    localparam logic [1:0] REG_CTRL     = 2'd0;
    localparam logic [1:0] REG_TIMER_LO = 2'd1;
    localparam logic [1:0] REG_TIMER_HI = 2'd2;
    localparam logic [1:0] REG_ENABLE   = 2'd3;

    // Bit n of each pattern is the output level at sequencer step n.
    localparam logic [7:0] DUTY_0 = 8'b0000_0010;
    localparam logic [7:0] DUTY_1 = 8'b0000_0110;
    localparam logic [7:0] DUTY_2 = 8'b0001_1110;
    localparam logic [7:0] DUTY_3 = 8'b1111_1001;

    localparam logic [3:0][7:0] DUTY_TABLE = {DUTY_3, DUTY_2, DUTY_1, DUTY_0};

    localparam logic [7:0] LEN_TABLE [32] = '{
        8'd10,  8'd254, 8'd20,  8'd2,   8'd40,  8'd4,   8'd80,  8'd6,
        8'd160, 8'd8,   8'd60,  8'd10,  8'd14,  8'd12,  8'd26,  8'd14,
        8'd12,  8'd16,  8'd24,  8'd18,  8'd48,  8'd20,  8'd96,  8'd22,
        8'd192, 8'd24,  8'd72,  8'd26,  8'd16,  8'd28,  8'd32,  8'd30
    };

    function automatic logic duty_bit(input logic [1:0] duty, input logic [2:0] step);
        return DUTY_TABLE[duty][step];
    endfunction

endpackage

// File: rtl/apu_envelope.sv
// Volume envelope: a decay level stepped by a divider on each quarter-frame tick,
// optionally looping back to 15. Only instantiated under APU_PULSE_ENVELOPE_EN.
module apu_envelope (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_qtick,
    input  logic       i_start,
    input  logic       i_loop,
    input  logic [3:0] i_period,
    output logic [3:0] o_decay
);

    logic       r_start;
    logic [3:0] r_div;
    logic [3:0] r_decay;

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_start <= 1'b0;
            r_div   <= 4'd0;
            r_decay <= 4'd0;
        end else begin
            if (i_qtick) begin
                if (r_start) begin
                    r_start <= 1'b0;
                    r_decay <= 4'd15;
                    r_div   <= i_period;
                end else if (r_div == 4'd0) begin
                    r_div <= i_period;
                    if (r_decay != 4'd0)
                        r_decay <= r_decay - 4'd1;
                    else if (i_loop)
                        r_decay <= 4'd15;
                end else begin
                    r_div <= r_div - 4'd1;
                end
            end
            // A start request arriving with a qtick is kept for the following qtick.
            if (i_start)
                r_start <= 1'b1;
        end
    end

    assign o_decay = r_decay;

endmodule

// File: rtl/apu_pulse_channel.sv
// NES-style pulse voice: bus-mapped registers, duty sequencer, period timer and length counter.
// Define APU_PULSE_ENVELOPE_EN to include the volume envelope; otherwise volume is R0[3:0].
module apu_pulse_channel
    import apu_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR  = 8'hF0,
    parameter int         PRESCALE   = 2,
    parameter int         QFRAME_DIV = 7457
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] bus_addr,
    input  logic [7:0] bus_data,
    input  logic       bus_we,
    output logic [3:0] sample,
    output logic       active
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int QW = $clog2(QFRAME_DIV);

    logic [1:0]    r_duty;
    logic          r_halt;
    logic [3:0]    r_vol;
    logic [10:0]   r_period;
    logic          r_enable;
    logic [PW-1:0] r_presc;
    logic [10:0]   r_timer;
    logic [2:0]    r_step;
    logic [QW-1:0] r_qcnt;
    logic          r_half;
    logic [7:0]    r_length;
    logic [3:0]    r_sample;
    logic          r_active;

    logic [7:0] w_off;
    logic       w_sel;
    logic       w_wr_ctrl, w_wr_tlo, w_wr_thi, w_wr_en;
    logic       w_tick, w_qtick, w_htick;
    logic [3:0] w_vol;
    logic       w_mute;

    // Offset arithmetic keeps decoding correct for unaligned base addresses.
    assign w_off     = bus_addr - BASE_ADDR;
    assign w_sel     = bus_we && (w_off[7:2] == 6'd0);
    assign w_wr_ctrl = w_sel && (w_off[1:0] == REG_CTRL);
    assign w_wr_tlo  = w_sel && (w_off[1:0] == REG_TIMER_LO);
    assign w_wr_thi  = w_sel && (w_off[1:0] == REG_TIMER_HI);
    assign w_wr_en   = w_sel && (w_off[1:0] == REG_ENABLE);

    assign w_tick  = (r_presc == PW'(PRESCALE - 1));
    assign w_qtick = (r_qcnt == QW'(QFRAME_DIV - 1));
    assign w_htick = w_qtick && r_half;

`ifdef APU_PULSE_ENVELOPE_EN
    logic       r_const;
    logic [3:0] w_decay;

    apu_envelope u_envelope (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_qtick  (w_qtick),
        .i_start  (w_wr_thi),
        .i_loop   (r_halt),
        .i_period (r_vol),
        .o_decay  (w_decay)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_const <= 1'b0;
        else if (w_wr_ctrl)
            r_const <= bus_data[4];
    end

    assign w_vol = r_const ? r_vol : w_decay;
`else
    assign w_vol = r_vol;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_duty   <= 2'd0;
            r_halt   <= 1'b0;
            r_vol    <= 4'd0;
            r_period <= 11'd0;
            r_enable <= 1'b0;
        end else begin
            if (w_wr_ctrl) begin
                r_duty <= bus_data[7:6];
                r_halt <= bus_data[5];
                r_vol  <= bus_data[3:0];
            end
            if (w_wr_tlo)
                r_period[7:0] <= bus_data;
            if (w_wr_thi)
                r_period[10:8] <= bus_data[2:0];
            if (w_wr_en)
                r_enable <= bus_data[0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_qcnt  <= '0;
            r_half  <= 1'b0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + PW'(1);
            r_qcnt  <= w_qtick ? '0 : r_qcnt + QW'(1);
            if (w_qtick)
                r_half <= ~r_half;
        end
    end

    // Period writes never reload the timer; the new value is picked up at the next reload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timer <= 11'd0;
            r_step  <= 3'd0;
        end else begin
            if (w_tick) begin
                if (r_timer == 11'd0) begin
                    r_timer <= r_period;
                    r_step  <= r_step + 3'd1;
                end else begin
                    r_timer <= r_timer - 11'd1;
                end
            end
            if (w_wr_thi)
                r_step <= 3'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_length <= 8'd0;
        else if (w_wr_en && !bus_data[0])
            r_length <= 8'd0;
        else if (w_wr_thi && r_enable)
            r_length <= LEN_TABLE[bus_data[7:3]];
        else if (w_htick && (r_length != 8'd0) && !r_halt)
            r_length <= r_length - 8'd1;
    end

    assign w_mute = (r_length == 8'd0) || (r_period < 11'd8) || !duty_bit(r_duty, r_step);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sample <= 4'd0;
            r_active <= 1'b0;
        end else begin
            r_sample <= w_mute ? 4'd0 : w_vol;
            r_active <= (r_length != 8'd0);
        end
    end

    assign sample = r_sample;
    assign active = r_active;

endmodule
